// File: rtl/rr_prio_arbiter_if.sv
// Request/grant bundle between a set of requesters and the arbiter.
// The master side drives mode and requests; the slave side (the arbiter)
// returns the registered grant vector, owner index and valid flag.
interface rr_prio_arbiter_if #(
    parameter int N = 4
) ();
    localparam int IDW = $clog2(N);

    logic           mode;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    modport master (
        output mode,
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid
    );

    modport slave (
        input  mode,
        input  req,
        output grant,
        output grant_id,
        output grant_valid
    );
endinterface

// File: rtl/rr_prio_arbiter.sv
// N-way arbiter, fixed-priority or round-robin selectable at run time.
// The grant is registered and stays with its owner while it keeps requesting;
// after MAX_HOLD consecutive cycles the owner is preempted if anyone else waits.
// All outputs come straight from flops, so there is no req->grant comb path.
module rr_prio_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    rr_prio_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    grant_r;
    logic [N-1:0]    grant_s;
    logic [IDW-1:0]  grant_id_r;
    logic [IDW-1:0]  grant_id_s;
    logic            grant_valid_r;
    logic            grant_valid_s;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  rr_ptr_s;
    logic [HCW-1:0]  hold_cnt_r;
    logic [HCW-1:0]  hold_cnt_s;
    logic            arb_en_s;
    logic [N-1:0]    arb_vec_s;
    logic [IDW-1:0]  win_s;
    logic            preempt_s;

    // First set bit of v, scanning upward from ptr (round-robin) or from 0
    // (fixed priority) and wrapping at N. Only called with a non-zero v.
    function automatic logic [IDW-1:0] pick(
        input logic [N-1:0]   v,
        input logic           rr,
        input logic [IDW-1:0] ptr
    );
        logic [IDW-1:0] result;
        logic           found;
        int             start;
        int             idx;
        result = '0;
        found  = 1'b0;
        start  = rr ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (!found && v[idx]) begin
                result = IDW'(idx);
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
        return result;
    endfunction

    assign preempt_s = (MAX_HOLD != 0)
                    && (int'(hold_cnt_r) == MAX_HOLD)
                    && ((bus.req & ~grant_r) != {N{1'b0}});

    // Next-state logic: decide keep / handover / preempt / release, then
    // apply the common "new owner" update when an arbitration happens.
    always_comb begin
        state_s       = state_r;
        grant_id_s    = grant_id_r;
        grant_valid_s = grant_valid_r;
        hold_cnt_s    = hold_cnt_r;
        rr_ptr_s      = rr_ptr_r;
        arb_en_s      = 1'b0;
        arb_vec_s     = {N{1'b0}};

        case (state_r)
            IDLE: begin
                if (bus.req != {N{1'b0}}) begin
                    arb_en_s  = 1'b1;
                    arb_vec_s = bus.req;
                end else begin
                    grant_valid_s = 1'b0;
                    grant_id_s    = {IDW{1'b0}};
                    hold_cnt_s    = {HCW{1'b0}};
                end
            end
            BUSY: begin
                if (!bus.req[grant_id_r]) begin
                    // Owner let go: hand over without a bubble, or go idle.
                    if (bus.req == {N{1'b0}}) begin
                        state_s       = IDLE;
                        grant_valid_s = 1'b0;
                        grant_id_s    = {IDW{1'b0}};
                        hold_cnt_s    = {HCW{1'b0}};
                    end else begin
                        arb_en_s  = 1'b1;
                        arb_vec_s = bus.req;
                    end
                end else if (preempt_s) begin
                    arb_en_s  = 1'b1;
                    arb_vec_s = bus.req & ~grant_r;
                end else begin
                    if (int'(hold_cnt_r) < MAX_HOLD) begin
                        hold_cnt_s = hold_cnt_r + HCW'(1);
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                state_s       = IDLE;
                grant_valid_s = 1'b0;
                grant_id_s    = {IDW{1'b0}};
                hold_cnt_s    = {HCW{1'b0}};
            end
        endcase

        win_s = pick(arb_vec_s, bus.mode, rr_ptr_r);

        if (arb_en_s) begin
            state_s       = BUSY;
            grant_valid_s = 1'b1;
            grant_id_s    = win_s;
            hold_cnt_s    = HCW'(1);
            if (bus.mode) begin
                rr_ptr_s = (win_s == IDW'(N - 1)) ? {IDW{1'b0}} : win_s + IDW'(1);
            end else begin
                rr_ptr_s = rr_ptr_r;
            end
        end else begin
            rr_ptr_s = rr_ptr_r;
        end

        if (grant_valid_s) begin
            grant_s = N'(1) << grant_id_s;
        end else begin
            grant_s = {N{1'b0}};
        end
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            grant_r       <= {N{1'b0}};
            grant_id_r    <= {IDW{1'b0}};
            grant_valid_r <= 1'b0;
            rr_ptr_r      <= {IDW{1'b0}};
            hold_cnt_r    <= {HCW{1'b0}};
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            grant_id_r    <= grant_id_s;
            grant_valid_r <= grant_valid_s;
            rr_ptr_r      <= rr_ptr_s;
            hold_cnt_r    <= hold_cnt_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.grant_valid = grant_valid_r;
endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Bench for rr_prio_arbiter (N=4, MAX_HOLD=4): directed vector table,
// hand-written reset sequence, and randomized traffic against a reference model.
module tb_rr_prio_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    rr_prio_arbiter_if #(.N(N)) bus ();

    rr_prio_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner index (-1 = nobody), consecutive cycles, rr pointer.
    int m_owner;
    int m_hold;
    int m_ptr;

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic [3:0] exp;
        int         tag;
    } vec_t;

    vec_t tbl[$];

    // Invariants on the registered outputs.
    a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $countones(bus.grant) <= 1);
    a_rise_req: assert property (@(posedge clk) disable iff (!reset_n)
        ((bus.grant & ~$past(bus.grant)) & ~$past(bus.req)) == 4'b0000);
    a_noreq_nogrant: assert property (@(posedge clk) disable iff (!reset_n)
        ($past(bus.req) == 4'b0000) |-> (bus.grant == 4'b0000));
    a_consistent: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.grant_valid == (|bus.grant)) &&
        (bus.grant_valid ? (bus.grant == (4'b0001 << bus.grant_id)) : (bus.grant_id == 2'd0)));

    function automatic int m_pick(logic [3:0] v, logic rr, int p);
        int start;
        start = rr ? p : 0;
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_new_owner(logic [3:0] v, logic m);
        m_owner = m_pick(v, m, m_ptr);
        m_hold  = 1;
        if (m) m_ptr = (m_owner + 1) % N;
    endtask

    // One clock edge of the arbitration rules applied to the sampled req/mode.
    task automatic model_step(logic [3:0] r, logic m);
        logic [3:0] others;
        if (m_owner < 0) begin
            if (r != 4'b0000) model_new_owner(r, m);
        end else if (!r[m_owner]) begin
            if (r == 4'b0000) begin
                m_owner = -1;
                m_hold  = 0;
            end else begin
                model_new_owner(r, m);
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (m_hold == MAX_HOLD && others != 4'b0000) model_new_owner(others, m);
            else if (m_hold < MAX_HOLD) m_hold = m_hold + 1;
        end
    endtask

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic check_out(string name, logic [3:0] eg);
        logic [1:0] eid;
        logic       ev;
        eid = 2'd0;
        ev  = |eg;
        for (int i = 0; i < N; i++) if (eg[i]) eid = 2'(i);
        checks++;
        if (bus.grant !== eg || bus.grant_id !== eid || bus.grant_valid !== ev) begin
            failures++;
            $display("FAIL %s: got grant=%b id=%0d valid=%b, expected grant=%b id=%0d valid=%b",
                     name, bus.grant, bus.grant_id, bus.grant_valid, eg, eid, ev);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic add(logic [3:0] r, logic m, logic [3:0] e, int n, int tag);
        for (int i = 0; i < n; i++) tbl.push_back('{req: r, mode: m, exp: e, tag: tag});
    endtask

    initial begin
        logic [3:0] r;
        logic       m;

        bus.req  = 4'b0000;
        bus.mode = 1'b0;
        model_reset();

        // Reset state and asynchronous reset mid-grant.
        do_reset();
        check_out("reset_state", 4'b0000);
        bus.req  = 4'b0010;
        bus.mode = 1'b0;
        tick();
        check_out("t1_pre_reset", 4'b0010);
        #2 reset_n = 1'b0;
        #1 check_out("t1_async_clear", 4'b0000);
        #1 reset_n = 1'b1;
        bus.req  = 4'b1111;
        bus.mode = 1'b1;
        tick();
        check_out("t1_first_after_release", 4'b0001);

        // Directed vector table.
        add(4'b1010, 1'b0, 4'b0010, 4, 2);
        add(4'b1010, 1'b0, 4'b1000, 1, 2);
        add(4'b0010, 1'b0, 4'b0010, 1, 2);
        add(4'b0000, 1'b0, 4'b0000, 1, 2);
        add(4'b1111, 1'b1, 4'b0001, 4, 3);
        add(4'b1111, 1'b1, 4'b0010, 4, 3);
        add(4'b1111, 1'b1, 4'b0100, 4, 3);
        add(4'b1111, 1'b1, 4'b1000, 4, 3);
        add(4'b1111, 1'b1, 4'b0001, 1, 3);
        add(4'b0100, 1'b1, 4'b0100, 12, 4);
        add(4'b0000, 1'b1, 4'b0000, 1, 4);
        add(4'b0001, 1'b1, 4'b0001, 1, 5);
        add(4'b1000, 1'b1, 4'b1000, 1, 5);
        add(4'b0000, 1'b1, 4'b0000, 1, 5);
        add(4'b0100, 1'b1, 4'b0100, 1, 6);
        add(4'b0110, 1'b0, 4'b0100, 2, 6);
        add(4'b0011, 1'b0, 4'b0001, 1, 6);
        add(4'b0000, 1'b0, 4'b0000, 1, 6);

        do_reset();
        foreach (tbl[i]) begin
            bus.req  = tbl[i].req;
            bus.mode = tbl[i].mode;
            tick();
            check_out($sformatf("vec%0d_t%0d", i, tbl[i].tag), tbl[i].exp);
        end

        // Randomized traffic against the reference model, with occasional
        // asynchronous resets landing in the middle of a cycle.
        do_reset();
        r = 4'b0000;
        m = 1'b1;
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) m = ~m;
            bus.req  = r;
            bus.mode = m;
            if ($urandom_range(0, 59) == 0) begin
                #2 reset_n = 1'b0;
                #1 check_out($sformatf("rnd%0d_async", it), 4'b0000);
                model_reset();
                #1 reset_n = 1'b1;
            end
            tick();
            model_step(r, m);
            check_out($sformatf("rnd%0d", it), m_grant());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
